// File: rtl/rf_pkg.sv
// Shared constants, instruction field positions and FSM state type
// for the register-bank operand sequencer.
package rf_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int NREGS  = 2 ** ADDR_W;

    localparam int OPC_LSB = 12;
    localparam int DST_LSB = 8;
    localparam int SRA_LSB = 4;
    localparam int SRB_LSB = 0;
    localparam int OPC_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

endpackage

// File: rtl/rf_operand_sequencer_if.sv
// Instruction, bank, ALU-issue and writeback signals of the sequencer.
// master = sequencer side, slave = environment (bank, ALU, fetch).
interface rf_operand_sequencer_if #(
    parameter int DW = rf_pkg::DATA_W,
    parameter int AW = rf_pkg::ADDR_W
);

    logic          instr_valid;
    logic [15:0]   instr;
    logic          instr_ready;

    logic [AW-1:0] rf_reg_a;
    logic [AW-1:0] rf_reg_b;
    logic [DW-1:0] rf_data_a;
    logic [DW-1:0] rf_data_b;
    logic [AW-1:0] rf_reg_c;
    logic [DW-1:0] rf_dado;
    logic          rf_rw;

    logic          op_valid;
    logic          op_ready;
    logic [3:0]    op_opcode;
    logic [AW-1:0] op_dest;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;

    logic          wb_valid;
    logic [AW-1:0] wb_dest;
    logic [DW-1:0] wb_data;
    logic          wb_ready;

    modport master (
        input  instr_valid, instr,
        output instr_ready,
        output rf_reg_a, rf_reg_b,
        input  rf_data_a, rf_data_b,
        output rf_reg_c, rf_dado, rf_rw,
        output op_valid,
        input  op_ready,
        output op_opcode, op_dest, op_a, op_b,
        input  wb_valid, wb_dest, wb_data,
        output wb_ready
    );

    modport slave (
        output instr_valid, instr,
        input  instr_ready,
        input  rf_reg_a, rf_reg_b,
        output rf_data_a, rf_data_b,
        input  rf_reg_c, rf_dado, rf_rw,
        input  op_valid,
        output op_ready,
        input  op_opcode, op_dest, op_a, op_b,
        output wb_valid, wb_dest, wb_data,
        input  wb_ready
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-result vector: one bit per register, set on issue,
// cleared on writeback, queried for three indices at once.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int AW = rf_pkg::ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_en,
    input  logic [AW-1:0] set_idx,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_idx,
    input  logic [AW-1:0] q_a,
    input  logic [AW-1:0] q_b,
    input  logic [AW-1:0] q_d,
    output logic          hit_a,
    output logic          hit_b,
    output logic          hit_d
);

    localparam int N = 2 ** AW;

    logic [N-1:0] pending;
    logic [N-1:0] set_vec;
    logic [N-1:0] clr_vec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_en) set_vec[set_idx] = 1'b1;
        if (clr_en) clr_vec[clr_idx] = 1'b1;
    end

    // A new issue wins over a writeback to a register that was not pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= (pending & ~clr_vec) | set_vec;
    end

    assign hit_a = pending[q_a];
    assign hit_b = pending[q_b];
    assign hit_d = pending[q_d];

endmodule

// File: rtl/rf_operand_sequencer.sv
// Register-bank operand sequencer: read, issue to ALU, commit writebacks.
// Optional RF_WB_FORWARD_EN lets a same-cycle writeback satisfy a source hazard.
module rf_operand_sequencer
    import rf_pkg::*;
#(
    parameter int DATA_W = rf_pkg::DATA_W,
    parameter int ADDR_W = rf_pkg::ADDR_W
) (
    input logic clk,
    input logic rst_n,
    rf_operand_sequencer_if.master bus
);

    state_t state;

    logic [ADDR_W-1:0] src_a;
    logic [ADDR_W-1:0] src_b;
    logic [ADDR_W-1:0] dst;
    logic [OPC_W-1:0]  opc;

    logic hit_a, hit_b, hit_d;
    logic fwd_a, fwd_b;
    logic stall, ready, accept, wb_fire;
    logic alive;

    logic              fa_q, fb_q;
    logic [DATA_W-1:0] fwd_data_q;

    logic [ADDR_W-1:0] reg_a_q, reg_b_q, reg_c_q, op_dest_q;
    logic [DATA_W-1:0] dado_q, op_a_q, op_b_q;
    logic [OPC_W-1:0]  op_opc_q;
    logic              rw_q, op_valid_q;

    assign opc   = bus.instr[OPC_LSB +: OPC_W];
    assign dst   = bus.instr[DST_LSB +: ADDR_W];
    assign src_a = bus.instr[SRA_LSB +: ADDR_W];
    assign src_b = bus.instr[SRB_LSB +: ADDR_W];

    assign wb_fire = bus.wb_valid && alive;

`ifdef RF_WB_FORWARD_EN
    assign fwd_a = wb_fire && (bus.wb_dest == src_a);
    assign fwd_b = wb_fire && (bus.wb_dest == src_b);
`else
    assign fwd_a = 1'b0;
    assign fwd_b = 1'b0;
`endif

    assign stall  = (hit_a && !fwd_a) || (hit_b && !fwd_b) || hit_d;
    assign ready  = (state == ST_IDLE) && alive && !stall;
    assign accept = bus.instr_valid && ready;

    rf_scoreboard #(.AW(ADDR_W)) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (accept),
        .set_idx (dst),
        .clr_en  (wb_fire),
        .clr_idx (bus.wb_dest),
        .q_a     (src_a),
        .q_b     (src_b),
        .q_d     (dst),
        .hit_a   (hit_a),
        .hit_b   (hit_b),
        .hit_d   (hit_d)
    );

    // alive doubles as wb_ready: low in reset, high from the first clock after
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive   <= 1'b0;
            rw_q    <= 1'b0;
            reg_c_q <= '0;
            dado_q  <= '0;
        end else begin
            alive <= 1'b1;
            rw_q  <= wb_fire;
            if (wb_fire) begin
                reg_c_q <= bus.wb_dest;
                dado_q  <= bus.wb_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            reg_a_q    <= '0;
            reg_b_q    <= '0;
            op_opc_q   <= '0;
            op_dest_q  <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_valid_q <= 1'b0;
            fa_q       <= 1'b0;
            fb_q       <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        reg_a_q    <= src_a;
                        reg_b_q    <= src_b;
                        op_opc_q   <= opc;
                        op_dest_q  <= dst;
                        fa_q       <= fwd_a;
                        fb_q       <= fwd_b;
                        fwd_data_q <= bus.wb_data;
                        state      <= ST_READ;
                    end
                end
                ST_READ: begin
                    op_a_q     <= fa_q ? fwd_data_q : bus.rf_data_a;
                    op_b_q     <= fb_q ? fwd_data_q : bus.rf_data_b;
                    op_valid_q <= 1'b1;
                    state      <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (bus.op_ready) begin
                        op_valid_q <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.instr_ready = ready;
    assign bus.rf_reg_a    = reg_a_q;
    assign bus.rf_reg_b    = reg_b_q;
    assign bus.rf_reg_c    = reg_c_q;
    assign bus.rf_dado     = dado_q;
    assign bus.rf_rw       = rw_q;
    assign bus.op_valid    = op_valid_q;
    assign bus.op_opcode   = op_opc_q;
    assign bus.op_dest     = op_dest_q;
    assign bus.op_a        = op_a_q;
    assign bus.op_b        = op_b_q;
    assign bus.wb_ready    = alive;

endmodule

// File: tb/tb_rf_operand_sequencer.sv
// Scoreboarded bench for rf_operand_sequencer with a behavioural
// 16x16 register bank attached to its read/write ports.
module tb_rf_operand_sequencer;

    typedef struct {
        logic [3:0]  opc;
        logic [3:0]  dest;
        logic [15:0] a;
        logic [15:0] b;
    } op_exp_t;

    typedef struct {
        logic [3:0]  dest;
        logic [15:0] data;
    } wb_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    op_exp_t op_q[$];
    wb_exp_t wb_q[$];
    op_exp_t oe;
    wb_exp_t we;

    logic [15:0] bank [16];

`ifdef RF_WB_FORWARD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    rf_operand_sequencer_if bus ();

    rf_operand_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) bank[i] <= 16'h0;
        end else if (bus.rf_rw) begin
            bank[bus.rf_reg_c] <= bus.rf_dado;
        end
    end

    assign bus.rf_data_a = bank[bus.rf_reg_a];
    assign bus.rf_data_b = bank[bus.rf_reg_b];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bus.instr_valid = 1'b0;
        bus.instr = 16'h0;
        bus.op_ready = 1'b0;
        bus.wb_valid = 1'b0;
        bus.wb_dest = 4'h0;
        bus.wb_data = 16'h0;
        rst_n = 1'b0;
        #3;
        checks++;
        if (bus.op_valid !== 1'b0 || bus.rf_rw !== 1'b0 ||
            bus.wb_ready !== 1'b0 || bus.instr_ready !== 1'b0 ||
            bus.rf_reg_a !== 4'h0 || bus.op_a !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got ov=%b rw=%b wbr=%b ir=%b ra=%h oa=%h want all 0",
                     bus.op_valid, bus.rf_rw, bus.wb_ready,
                     bus.instr_ready, bus.rf_reg_a, bus.op_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.wb_ready !== 1'b0) begin
            errors++;
            $display("FAIL wb_ready_before_clk: got %b want 0", bus.wb_ready);
        end
        tick();
        checks++;
        if (bus.wb_ready !== 1'b1 || bus.instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_clk: got wbr=%b ir=%b want 1 1",
                     bus.wb_ready, bus.instr_ready);
        end
    endtask

    task automatic test_writeback;
        bus.wb_valid = 1'b1;
        bus.wb_dest = 4'd3;
        bus.wb_data = 16'h00A5;
        wb_q.push_back('{dest: 4'd3, data: 16'h00A5});
        tick();
        bus.wb_valid = 1'b0;
        checks++;
        if (wb_q.size() == 0) begin
            errors++;
            $display("FAIL wb_single: scoreboard empty");
        end else begin
            we = wb_q.pop_front();
            if (bus.rf_rw !== 1'b1 || bus.rf_reg_c !== we.dest ||
                bus.rf_dado !== we.data) begin
                errors++;
                $display("FAIL wb_single: got rw=%b c=%h d=%h want 1 %h %h",
                         bus.rf_rw, bus.rf_reg_c, bus.rf_dado, we.dest, we.data);
            end
        end
        tick();
        checks++;
        if (bus.rf_rw !== 1'b0) begin
            errors++;
            $display("FAIL wb_pulse_width: got rw=%b want 0", bus.rf_rw);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  d [2];
        logic [15:0] v [2];
        d[0] = 4'd1; v[0] = 16'h1111;
        d[1] = 4'd2; v[1] = 16'h2222;
        for (int i = 0; i < 2; i++) begin
            bus.wb_valid = 1'b1;
            bus.wb_dest = d[i];
            bus.wb_data = v[i];
            wb_q.push_back('{dest: d[i], data: v[i]});
            tick();
            if (i == 1) bus.wb_valid = 1'b0;
            checks++;
            we = wb_q.pop_front();
            if (bus.rf_rw !== 1'b1 || bus.rf_reg_c !== we.dest ||
                bus.rf_dado !== we.data) begin
                errors++;
                $display("FAIL wb_b2b_%0d: got rw=%b c=%h d=%h want 1 %h %h",
                         i, bus.rf_rw, bus.rf_reg_c, bus.rf_dado, we.dest, we.data);
            end
        end
        tick();
        checks++;
        if (bus.rf_rw !== 1'b0) begin
            errors++;
            $display("FAIL wb_b2b_end: got rw=%b want 0", bus.rf_rw);
        end
    endtask

    task automatic test_issue_hold;
        bus.instr = 16'h5312;
        bus.instr_valid = 1'b1;
        #1;
        checks++;
        if (bus.instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_accept: got ir=%b want 1", bus.instr_ready);
        end
        op_q.push_back('{opc: 4'd5, dest: 4'd3, a: 16'h1111, b: 16'h2222});
        tick();
        bus.instr_valid = 1'b0;
        bus.instr = 16'h0;
        checks++;
        if (bus.rf_reg_a !== 4'd1 || bus.rf_reg_b !== 4'd2 ||
            bus.op_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_addr: got a=%h b=%h ov=%b want 1 2 0",
                     bus.rf_reg_a, bus.rf_reg_b, bus.op_valid);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.op_valid !== 1'b1 || bus.op_a !== op_q[0].a ||
                bus.op_b !== op_q[0].b || bus.instr_ready !== 1'b0) begin
                errors++;
                $display("FAIL issue_hold_%0d: got ov=%b a=%h b=%h ir=%b want 1 %h %h 0",
                         i, bus.op_valid, bus.op_a, bus.op_b,
                         bus.instr_ready, op_q[0].a, op_q[0].b);
            end
            tick();
        end
        bus.op_ready = 1'b1;
        oe = op_q.pop_front();
        checks++;
        if (bus.op_valid !== 1'b1 || bus.op_opcode !== oe.opc ||
            bus.op_dest !== oe.dest || bus.op_a !== oe.a || bus.op_b !== oe.b) begin
            errors++;
            $display("FAIL issue_ops: got ov=%b op=%h d=%h a=%h b=%h want 1 %h %h %h %h",
                     bus.op_valid, bus.op_opcode, bus.op_dest, bus.op_a,
                     bus.op_b, oe.opc, oe.dest, oe.a, oe.b);
        end
        tick();
        bus.op_ready = 1'b0;
        checks++;
        if (bus.op_valid !== 1'b0 || bus.instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_release: got ov=%b ir=%b want 0 1",
                     bus.op_valid, bus.instr_ready);
        end
    endtask

    task automatic test_hazard;
        bus.instr = 16'h6434;
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.instr_ready !== 1'b0) begin
                errors++;
                $display("FAIL hazard_stall_%0d: got ir=%b want 0", i, bus.instr_ready);
            end
            tick();
        end
        bus.wb_valid = 1'b1;
        bus.wb_dest = 4'd3;
        bus.wb_data = 16'h0BEE;
        wb_q.push_back('{dest: 4'd3, data: 16'h0BEE});
        #1;
        checks++;
        if (bus.instr_ready !== FWD) begin
            errors++;
            $display("FAIL hazard_wb_cycle: got ir=%b want %b", bus.instr_ready, FWD);
        end
        if (FWD) op_q.push_back('{opc: 4'd6, dest: 4'd4, a: 16'h0BEE, b: 16'h0});
        tick();
        bus.wb_valid = 1'b0;
        if (FWD) bus.instr_valid = 1'b0;
        checks++;
        we = wb_q.pop_front();
        if (bus.rf_rw !== 1'b1 || bus.rf_reg_c !== we.dest || bus.rf_dado !== we.data) begin
            errors++;
            $display("FAIL hazard_wb: got rw=%b c=%h d=%h want 1 %h %h",
                     bus.rf_rw, bus.rf_reg_c, bus.rf_dado, we.dest, we.data);
        end
        if (!FWD) begin
            checks++;
            if (bus.instr_ready !== 1'b1) begin
                errors++;
                $display("FAIL hazard_release: got ir=%b want 1", bus.instr_ready);
            end
            op_q.push_back('{opc: 4'd6, dest: 4'd4, a: 16'h0BEE, b: 16'h0});
            tick();
            bus.instr_valid = 1'b0;
        end
        for (int i = 0; i < 8 && bus.op_valid !== 1'b1; i++) tick();
        checks++;
        if (bus.op_valid !== 1'b1) begin
            errors++;
            $display("FAIL hazard_timeout: got ov=%b want 1", bus.op_valid);
        end else begin
            oe = op_q.pop_front();
            if (bus.op_opcode !== oe.opc || bus.op_dest !== oe.dest ||
                bus.op_a !== oe.a || bus.op_b !== oe.b) begin
                errors++;
                $display("FAIL hazard_ops: got op=%h d=%h a=%h b=%h want %h %h %h %h",
                         bus.op_opcode, bus.op_dest, bus.op_a, bus.op_b,
                         oe.opc, oe.dest, oe.a, oe.b);
            end
        end
        bus.op_ready = 1'b1;
        tick();
        bus.op_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        bus.instr = 16'h7120;
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        bus.instr = 16'h0;
        tick();
        bus.wb_valid = 1'b1;
        bus.wb_dest = 4'd5;
        bus.wb_data = 16'h5555;
        tick();
        bus.wb_valid = 1'b0;
        checks++;
        if (bus.op_valid !== 1'b1 || bus.rf_rw !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_state: got ov=%b rw=%b want 1 1",
                     bus.op_valid, bus.rf_rw);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.op_valid !== 1'b0 || bus.rf_rw !== 1'b0 ||
            bus.wb_ready !== 1'b0 || bus.instr_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got ov=%b rw=%b wbr=%b ir=%b want 0 0 0 0",
                     bus.op_valid, bus.rf_rw, bus.wb_ready, bus.instr_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.op_valid !== 1'b0 || bus.rf_rw !== 1'b0) begin
                errors++;
                $display("FAIL stale_after_reset_%0d: got ov=%b rw=%b want 0 0",
                         i, bus.op_valid, bus.rf_rw);
            end
        end
        bus.instr = 16'h8404;
        bus.instr_valid = 1'b1;
        #1;
        checks++;
        if (bus.instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL pending_cleared: got ir=%b want 1", bus.instr_ready);
        end
        op_q.push_back('{opc: 4'd8, dest: 4'd4, a: 16'h0, b: 16'h0});
        tick();
        bus.instr_valid = 1'b0;
        for (int i = 0; i < 8 && bus.op_valid !== 1'b1; i++) tick();
        checks++;
        if (bus.op_valid !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_timeout: got ov=%b want 1", bus.op_valid);
        end else begin
            oe = op_q.pop_front();
            if (bus.op_opcode !== oe.opc || bus.op_dest !== oe.dest ||
                bus.op_a !== oe.a || bus.op_b !== oe.b) begin
                errors++;
                $display("FAIL post_reset_ops: got op=%h d=%h a=%h b=%h want %h %h %h %h",
                         bus.op_opcode, bus.op_dest, bus.op_a, bus.op_b,
                         oe.opc, oe.dest, oe.a, oe.b);
            end
        end
        bus.op_ready = 1'b1;
        tick();
        bus.op_ready = 1'b0;
        checks++;
        if (op_q.size() != 0 || wb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got op=%0d wb=%0d want 0 0",
                     op_q.size(), wb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_writeback();
        test_back_to_back();
        test_issue_hold();
        test_hazard();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_operand_sequencer.md
Name: rf_operand_sequencer

Overview:
- Initiator-side controller for the 16x16-bit register bank.
- Accepts 16-bit instructions and drives the bank's read addresses (A/B) and write port (C, data, RW).
- Captures both source operands, issues them to the ALU stage with a valid/ready handshake, and commits ALU results back via a writeback port.
- A 16-entry scoreboard stalls instructions whose sources or destination have a result still in flight.

Parameters:
- DATA_W, 16, operand/result width; must match bank data width.
- ADDR_W, 4, register index width; NREGS = 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered.
- instr  in  16  [15:12] opcode, [11:8] dest, [7:4] srcA, [3:0] srcB.
- instr_ready  out  1  instruction accepted when valid&&ready.
- rf_reg_a  out  ADDR_W  bank read address A.
- rf_reg_b  out  ADDR_W  bank read address B.
- rf_data_a  in  DATA_W  bank read data A.
- rf_data_b  in  DATA_W  bank read data B.
- rf_reg_c  out  ADDR_W  bank write address.
- rf_dado  out  DATA_W  bank write data.
- rf_rw  out  1  1 = write this cycle, 0 = read only.
- op_valid  out  1  operands valid to ALU.
- op_ready  in  1  ALU accepts.
- op_opcode  out  4  opcode.
- op_dest  out  ADDR_W  destination.
- op_a  out  DATA_W  operand A.
- op_b  out  DATA_W  operand B.
- wb_valid  in  1  result offered.
- wb_dest  in  ADDR_W  result destination.
- wb_data  in  DATA_W  result value.
- wb_ready  out  1  result accepted.

Behaviour:
- Reset: state IDLE; pending=0; all outputs 0 except wb_ready=0. wb_ready goes to 1 on the first clock after reset deassertion.
- Reset mid-operation discards the in-flight instruction and any queued writeback.
- FSM IDLE -> READ -> ISSUE -> IDLE.
- IDLE: instr_ready=1 iff pending[srcA], pending[srcB] and pending[dest] are all 0. On accept:
  - latch fields;
  - drive rf_reg_a=srcA, rf_reg_b=srcB (registered, so they appear next cycle);
  - set pending[dest];
  - go to READ.
- READ: one cycle with addresses stable. Sample rf_data_a/b at the end of this cycle into op_a/op_b. Go to ISSUE.
- ISSUE: op_valid=1 and all op_* fields held stable until op_ready. On handshake, op_valid drops next cycle and the FSM returns to IDLE. Minimum issue interval is 3 cycles.
- Writeback:
  - wb_ready=1 always after reset.
  - On wb_valid, the next cycle registers rf_reg_c=wb_dest, rf_dado=wb_data, rf_rw=1 for exactly one cycle, then rf_rw=0.
  - pending[wb_dest] clears in the same cycle rf_rw=1 is driven.
  - Back-to-back writebacks give consecutive one-cycle rf_rw pulses.
- Stall check uses the registered pending vector only; no combinational bypass unless the Optional Feature is compiled in.
- Simultaneous set/clear on different indices: both take effect.
- Same-index set and clear cannot coincide, because an instruction with a pending dest is not accepted.
- Writeback to a non-pending register: the write is still performed and pending is unchanged (0).
- rf_rw is never asserted other than by writeback.
- Read addresses hold their last value outside READ.

Optional Feature:
- Macro RF_WB_FORWARD_EN.
- Defined: in IDLE, a source whose pending bit is set does not stall if wb_valid is high that cycle with wb_dest equal to that source.
  - The instruction is accepted and wb_data is captured as that operand, overriding the bank sample in READ.
  - The dest hazard still stalls.
- Undefined: a pending source always stalls until the clear cycle has passed.

Decomposition:
- Shared package rf_pkg: DATA_W/ADDR_W constants, instruction field position constants, FSM state enum (ST_IDLE, ST_READ, ST_ISSUE).
- One sub-module, rf_scoreboard: the pending vector with set/clear ports and a combinational hazard query for three indices.

Test Plan:
- Reset, then writeback dest=3 data=16'h00A5 -> next cycle rf_rw=1, rf_reg_c=3, rf_dado=16'h00A5 for exactly 1 cycle.
- Bank preloaded R1=16'h1111, R2=16'h2222; instr 16'h5312 -> rf_reg_a=1, rf_reg_b=2 in READ; op_valid with op_a=16'h1111, op_b=16'h2222, op_dest=3, op_opcode=5.
- Hold op_ready=0 for 4 cycles -> op_* stable, instr_ready=0; release -> op_valid drops next cycle, IDLE.
- Issue dest=3, then instr 16'h6434 -> instr_ready=0 until the rf_rw cycle for R3; then accepted, op_a = written value.
- With RF_WB_FORWARD_EN: wb_valid dest=3 data=16'h0BEE in the same cycle as a stalled srcA=3 instr -> accepted that cycle, op_a=16'h0BEE.
- Assert rst_n=0 during ISSUE -> op_valid=0, pending=0, rf_rw=0 immediately; no stale issue after release.
